// File: rtl/cla_slice_sequencer_if.sv
// Operand/result handshake bundle for the CLA slice sequencer.
// master = operand source and result sink, slave = sequencer.
interface cla_slice_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/cla_slice_sequencer.sv
// Wide adder built from repeated passes through one external CLA slice,
// LSB slice first, with the inter-slice carry held in a register.
module cla_slice_sequencer #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   cla_slice_sequencer_if.slave  io,
   output logic [SLICE-1:0]      sl_a,
   output logic [SLICE-1:0]      sl_b,
   output logic                  sl_cin,
   input  logic [SLICE-1:0]      sl_sum,
   input  logic                  sl_cout
);
   localparam int NSLICE = WIDTH / SLICE;
   localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state, state_nx;

   logic [IW-1:0]                 idx;
   logic                          carry;
   logic [NSLICE-1:0][SLICE-1:0]  a_reg;
   logic [NSLICE-1:0][SLICE-1:0]  b_reg;
   logic [NSLICE-1:0][SLICE-1:0]  sum_reg;
   logic                          cout_reg;
   logic                          ovf_reg;
   logic                          accept;
   logic                          last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      io.in_ready  = 1'b0;
      io.out_valid = 1'b0;
      sl_a         = '0;
      sl_b         = '0;
      sl_cin       = 1'b0;
      accept       = 1'b0;
      last         = (idx == LAST);
      unique case (state)
         IDLE: begin
            io.in_ready = 1'b1;
            if (io.in_valid) begin
               accept   = 1'b1;
               state_nx = RUN;
            end
         end
         RUN: begin
            sl_a   = a_reg[idx];
            sl_b   = b_reg[idx];
            sl_cin = carry;
            if (last) state_nx = DONE;
         end
         DONE: begin
            io.out_valid = 1'b1;
            if (io.out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Operands are frozen from capture until the next accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx      <= '0;
         carry    <= 1'b0;
         a_reg    <= '0;
         b_reg    <= '0;
         sum_reg  <= '0;
         cout_reg <= 1'b0;
         ovf_reg  <= 1'b0;
      end else begin
         if (accept) begin
            a_reg <= io.a;
            b_reg <= io.b;
            carry <= io.cin;
            idx   <= '0;
         end
         if (state == RUN) begin
            sum_reg[idx] <= sl_sum;
            carry        <= sl_cout;
            idx          <= last ? '0 : idx + 1'b1;
            if (last) begin
               cout_reg <= sl_cout;
               ovf_reg  <= (sl_a[SLICE-1] == sl_b[SLICE-1]) &&
                           (sl_sum[SLICE-1] != sl_a[SLICE-1]);
            end
         end
      end
   end

   assign io.sum  = sum_reg;
   assign io.cout = cout_reg;
   assign io.ovf  = ovf_reg;

endmodule

// File: doc/cla_slice_sequencer.md
Name: cla_slice_sequencer

Overview:
Multi-cycle controller that reuses one external 8-bit carry-lookahead adder slice to add wide operands, least-significant slice first. The carry from each slice is registered and fed into the next slice. Operands arrive and results leave on valid/ready handshakes. The block sits between the operand source and the CLA_8-bit datapath and is the only driver of the slice inputs.

Parameters:
WIDTH, 32, operand and result width in bits; must be an integer multiple of SLICE, minimum SLICE.
SLICE, 8, width of the external CLA slice in bits.
NSLICE (derived, not overridable), WIDTH/SLICE, number of slice passes per addition.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand source has a, b and cin valid.
in_ready  output  1  sequencer can accept operands.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry into bit 0.
out_valid  output  1  sum, cout and ovf are valid.
out_ready  input  1  sink accepts the result.
sum  output  WIDTH  registered result.
cout  output  1  carry out of the MSB.
ovf  output  1  two's-complement signed overflow.
sl_a  output  SLICE  A bits driven to the slice.
sl_b  output  SLICE  B bits driven to the slice.
sl_cin  output  1  carry driven to the slice.
sl_sum  input  SLICE  slice sum; combinational response to sl_a, sl_b and sl_cin within the same cycle.
sl_cout  input  1  slice carry out; combinational, same cycle.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, idx=0, carry register=0, operand registers=0.
  - in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, sl_a=0, sl_b=0, sl_cin=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture a, b and cin into internal registers; idx<=0; go to RUN.
  - sum, cout and ovf hold their previous values.
- RUN:
  - in_ready=0, out_valid=0.
  - Combinational slice drive: sl_a=a_reg[idx*SLICE +: SLICE], sl_b=b_reg[idx*SLICE +: SLICE], sl_cin=carry register.
  - Each cycle: sum[idx*SLICE +: SLICE]<=sl_sum; carry<=sl_cout; idx<=idx+1.
  - When idx==NSLICE-1:
    - cout<=sl_cout.
    - ovf<=(sl_a[SLICE-1]==sl_b[SLICE-1]) && (sl_sum[SLICE-1]!=sl_a[SLICE-1]).
    - Go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - sum, cout and ovf are stable.
  - On out_ready: go to IDLE.
- sl_a, sl_b and sl_cin are 0 outside RUN. The slice is never driven with stale operands.
- Latency: handshake accepted in cycle T; out_valid is asserted in cycle T+NSLICE+1. With WIDTH=32 that is 4 RUN cycles, so out_valid rises at T+5.
- Throughput: one addition per NSLICE+2 cycles with out_ready held high. There is no overlap; in_ready is never high in the same cycle as out_valid.
- Operand registers are frozen from capture to result. Changing a, b or cin after the handshake has no effect on the result.
- in_valid is ignored in RUN and DONE; no second capture occurs.
- out_valid stays high with sum, cout and ovf unchanged while out_ready is low, for any number of cycles.
- Arithmetic is unsigned modulo 2^WIDTH, plus carry. ovf is computed from the MSB of the final slice.
- idx width is ceil(log2(NSLICE)), minimum 1 bit. idx does not wrap, because the state leaves RUN at NSLICE-1.
- NSLICE==1: a single RUN cycle, then DONE.
- Reset asserted in any state aborts the operation immediately: all outputs return to their reset values and no partial result is presented.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, then high -> in_ready=1, out_valid=0, sum=0, sl_a=0, sl_b=0, sl_cin=0.
- Full carry ripple: a=32'hFFFF_FFFF, b=32'h0000_0001, cin=0 -> out_valid at T+5.
  - sum=32'h0000_0000, cout=1, ovf=0.
  - sl_cin=0,1,1,1 across the 4 RUN cycles.
- Signed overflow: a=32'h7FFF_FFFF, b=32'h0000_0001, cin=0 -> sum=32'h8000_0000, cout=0, ovf=1.
- Carry-in with backpressure: a=32'h1234_5678, b=32'h1111_1111, cin=1, out_ready held low for 6 cycles after out_valid.
  - sum=32'h2345_678A, cout=0, ovf=0, held stable throughout.
  - in_ready=0 and a second in_valid is ignored until the out_ready handshake.
- Reset mid-operation: assert rst_n low in the 2nd RUN cycle -> out_valid=0, sum=0 and in_ready=1 immediately.
  - After release, a=5, b=7, cin=0 -> sum=12, cout=0, ovf=0.
- Back-to-back throughput: out_ready tied to 1, two transactions.
  - First: a=1, b=2 -> sum=3.
  - Second: a=32'h8000_0000, b=32'h8000_0000 -> sum=0, cout=1, ovf=1.
  - Results are 6 cycles apart.
